// File: rtl/slave_addr_pkg.sv
// Shared definitions for the slave read-address burst generator.
// Holds entry field layout, burst encodings and FSM states.
package slave_addr_pkg;

    localparam int BURST_W = 2;
    localparam int SIZE_W  = 2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BURST
    } state_t;

    function automatic int len_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int burst_lsb(input int addr_w, input int len_w);
        return addr_w + len_w;
    endfunction

    function automatic int size_lsb(input int addr_w, input int len_w);
        return addr_w + len_w + BURST_W;
    endfunction

endpackage

// File: rtl/slave_addr_next_calc.sv
// Next beat address for FIXED, INCR and WRAP bursts.
// Purely combinational; unsupported WRAP lengths fall back to INCR.
module slave_addr_next_calc
    import slave_addr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic [ADDR_W-1:0] cur,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        burst,
    input  logic [1:0]        size,
    output logic [ADDR_W-1:0] next
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] step_mask;
    logic [ADDR_W-1:0] wrap_bytes;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] incr_next;
    logic [ADDR_W-1:0] wrap_next;
    logic              wrap_ok;

    // address arithmetic and burst-type selection
    always_comb begin
        step       = ADDR_W'(1) << size;
        step_mask  = step - ADDR_W'(1);
        wrap_bytes = (ADDR_W'(len) + ADDR_W'(1)) << size;
        wrap_mask  = wrap_bytes - ADDR_W'(1);
        base       = addr & ~wrap_mask;
        wrap_ok    = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                     (len == LEN_W'(7)) || (len == LEN_W'(15));
        incr_next  = (cur & ~step_mask) + step;
        wrap_next  = base + ((cur - base + step) & wrap_mask);
        next       = incr_next;
        unique case (1'b1)
            (burst == BURST_FIXED):           next = addr;
            (burst == BURST_WRAP) && wrap_ok: next = wrap_next;
            default:                          next = incr_next;
        endcase
    end

endmodule

// File: rtl/slave_addr_burst_gen.sv
// Pops address entries from an async FIFO read port and expands
// each into per-beat addresses with a valid/ready handshake.
module slave_addr_burst_gen
    import slave_addr_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int ENTRY_W = ADDR_W + LEN_W + 4
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    output logic               fifo_rd_en,
    input  logic [ENTRY_W-1:0] fifo_rd_data,
    input  logic               fifo_rd_empty,
    output logic               beat_valid,
    input  logic               beat_ready,
    output logic [ADDR_W-1:0]  beat_addr,
    output logic [LEN_W-1:0]   beat_idx,
    output logic               beat_last,
    output logic               busy
);

    localparam int LEN_LSB   = len_lsb(ADDR_W);
    localparam int BURST_LSB = burst_lsb(ADDR_W, LEN_W);
    localparam int SIZE_LSB  = size_lsb(ADDR_W, LEN_W);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        burst_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] next_addr;
    logic              rst_seen;

    assign beat_valid = (state == ST_BURST);
    assign beat_last  = (state == ST_BURST) && (beat_idx == len_q);
    assign busy       = (state != ST_IDLE);

    slave_addr_next_calc #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_next (
        .cur   (beat_addr),
        .addr  (addr_q),
        .len   (len_q),
        .burst (burst_q),
        .size  (size_q),
        .next  (next_addr)
    );

    // blocks popping until one clock edge has passed since reset
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) rst_seen <= 1'b0;
        else        rst_seen <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // next state and FIFO pop request
    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rst_seen && !fifo_rd_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nx   = ST_FETCH;
                end
            end
            ST_FETCH: state_nx = ST_BURST;
            ST_BURST: begin
                if (beat_ready && beat_last) begin
                    if (!fifo_rd_empty) begin
                        fifo_rd_en = 1'b1;
                        state_nx   = ST_FETCH;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // entry capture and per-beat address/index advance
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            size_q    <= '0;
            beat_addr <= '0;
            beat_idx  <= '0;
        end else if (state == ST_FETCH) begin
            addr_q    <= fifo_rd_data[ADDR_W-1:0];
            len_q     <= fifo_rd_data[LEN_LSB +: LEN_W];
            burst_q   <= fifo_rd_data[BURST_LSB +: BURST_W];
            size_q    <= fifo_rd_data[SIZE_LSB +: SIZE_W];
            beat_addr <= fifo_rd_data[ADDR_W-1:0];
            beat_idx  <= '0;
        end else if (state == ST_BURST && beat_ready && !beat_last) begin
            beat_addr <= next_addr;
            beat_idx  <= beat_idx + LEN_W'(1);
        end
    end

endmodule

// File: doc/slave_addr_burst_gen.md
SLAVE_ADDR_BURST_GEN -- requirements
Module: slave_addr_burst_gen

Interface
REQ-001 Parameter ADDR_W, default 32: beat address width.
REQ-002 Parameter LEN_W, default 8: AXI burst length field width.
REQ-003 Parameter ENTRY_W, default 44: FIFO entry width, equal to ADDR_W+LEN_W+4.
REQ-004 rd_clk  in  1  clock; all logic is on rd_clk.
REQ-005 rd_rst  in  1  reset, asynchronous, active-high.
REQ-006 fifo_rd_en  out  1  pop request to the async address FIFO read port.
REQ-007 fifo_rd_data  in  ENTRY_W  FIFO read data, valid the cycle after fifo_rd_en (no output register).
REQ-008 fifo_rd_empty  in  1  FIFO empty flag.
REQ-009 beat_valid  out  1  beat address valid.
REQ-010 beat_ready  in  1  downstream accepts the beat.
REQ-011 beat_addr  out  ADDR_W  per-beat byte address.
REQ-012 beat_idx  out  LEN_W  beat number within burst, 0..len.
REQ-013 beat_last  out  1  final beat of burst.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Entry layout: [31:0] addr, [39:32] len (beats-1), [41:40] burst (00 FIXED, 01 INCR, 10 WRAP, 11 reserved), [43:42] size (log2 bytes, 0..3).
REQ-016 FSM states IDLE, FETCH, BURST; reset state IDLE.
REQ-017 IDLE: if !fifo_rd_empty, assert fifo_rd_en for one cycle and go to FETCH; else stay.
REQ-018 FETCH: capture fifo_rd_data into addr/len/burst/size registers, beat_idx<=0, beat_addr<=addr, go to BURST.
REQ-019 BURST: beat_valid=1; outputs held stable while beat_valid && !beat_ready.
REQ-020 On beat handshake with beat_idx!=len: beat_idx+1, beat_addr<=next address per REQ-022..024.
REQ-021 On handshake with beat_last: if !fifo_rd_empty, assert fifo_rd_en in the same cycle and go to FETCH (exactly one bubble cycle between bursts); else go to IDLE.
REQ-022 FIXED: every beat uses the entry addr.
REQ-023 INCR and reserved: beat 0 = addr (unaligned allowed); beat n = (addr aligned down to 2^size) + n*2^size, modulo 2^ADDR_W.
REQ-024 WRAP: wrap_bytes=(len+1)<<size; base=addr aligned down to wrap_bytes; next = base + ((cur - base + 2^size) mod wrap_bytes); len+1 not in {2,4,8,16} is treated as INCR.
REQ-025 beat_last = (beat_idx == len) while in BURST; 0 otherwise.
REQ-026 Latency: fifo_rd_empty falling in IDLE at cycle T -> fifo_rd_en at T, beat_valid at T+2.
REQ-027 fifo_rd_en SHALL never be asserted while fifo_rd_empty=1 and never more than once per burst.
REQ-028 len=0: single beat, beat_last=1 on first beat.

Reset
REQ-029 rd_rst asserted forces immediately: state IDLE, fifo_rd_en=0, beat_valid=0, beat_last=0, busy=0, beat_addr=0, beat_idx=0, all captured fields 0.
REQ-030 Reset mid-burst discards the in-flight entry; no resumption after release.
REQ-031 First fifo_rd_en no earlier than the first rd_clk edge after rd_rst deassertion.

Structure
REQ-032 Shared package slave_addr_pkg holds field offsets/widths, burst encodings, and the state enum.
REQ-033 One combinational sub-module slave_addr_next_calc computes the next beat address from cur, addr, len, burst, size.
REQ-034 No other sub-modules; registered outputs only, no combinational path from beat_ready to fifo_rd_en except REQ-021's single-cycle pop.

Verification
REQ-035 INCR addr=0x1000, len=3, size=2 -> beats 0x1000,0x1004,0x1008,0x100C; beat_last on idx 3.
REQ-036 WRAP addr=0x1008, len=3, size=2 -> 0x1008,0x100C,0x1000,0x1004.
REQ-037 FIXED addr=0x2000, len=2, beat_ready toggling 1/0 -> three beats all 0x2000, outputs stable during stalls.
REQ-038 Two entries back-to-back, beat_ready=1 -> exactly one beat_valid=0 cycle between bursts; two fifo_rd_en pulses total.
REQ-039 INCR addr=0x1001, len=1, size=2 -> 0x1001, 0x1004.
REQ-040 rd_rst pulsed at beat 2 of len=7 burst -> all outputs 0 same cycle; after release, next pop only when fifo_rd_empty=0.
